// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch PC stage: state encoding, widths and
// reset defaults.
package pc_fetch_unit_pkg;

  localparam int          PC_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_PC_INC   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_BUBBLE = 2'd3
  } state_t;

  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_mux.sv
// 32-bit 2:1 select used for next-PC choice; sel=1 picks in2.
module bit32_2to1mux (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        sel,
  output logic [31:0] out
);

  assign out = sel ? in2 : in1;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch program counter: sequential/branch next-PC selection, fetch
// handshake, stall handling and deferred (pending) branch redirects.
//
// state  | meaning
// IDLE   | first cycle after reset, pc not yet presented
// RUN    | pc presented, advances on accept
// STALL  | pc presented but frozen by stall_i
// BUBBLE | one invalid cycle following a redirect
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        fetch_ready_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic [31:0] pc_plus4_o,
  output logic        redirect_o,
  output logic        misalign_err_o
);

  state_t      state, state_nxt;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] live_target;
  logic [31:0] branch_sel;
  logic [31:0] pc_nxt;
  logic        presenting;
  logic        can_redirect;
  logic        live_branch;
  logic        take_branch;
  logic        accept;
  logic        capture;

  assign presenting   = (state == ST_RUN) || (state == ST_STALL);
  assign pc_valid_o   = presenting;
  assign pc_plus4_o   = pc_o + 32'(PC_INC);
  assign live_target  = align_word(branch_target_i);

  assign can_redirect = presenting && !stall_i;
  assign live_branch  = can_redirect && branch_valid_i;
  assign take_branch  = live_branch || (can_redirect && pend_valid);
  assign accept       = presenting && fetch_ready_i && !stall_i;
  assign capture      = branch_valid_i && !live_branch;

  // A live branch is newer than anything pending, so it wins the select.
  assign branch_sel = live_branch ? live_target : pend_target;

  bit32_2to1mux u_next_pc_mux (
    .in1 (pc_plus4_o),
    .in2 (branch_sel),
    .sel (take_branch),
    .out (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_RUN;
      ST_RUN: begin
        if (take_branch)  state_nxt = ST_BUBBLE;
        else if (stall_i) state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (take_branch)   state_nxt = ST_BUBBLE;
        else if (!stall_i) state_nxt = ST_RUN;
      end
      ST_BUBBLE: state_nxt = stall_i ? ST_STALL : ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pc_o           <= RESET_PC;
      pend_valid     <= 1'b0;
      pend_target    <= '0;
      redirect_o     <= 1'b0;
      misalign_err_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      redirect_o <= take_branch;
      if (take_branch || accept) pc_o <= pc_nxt;
      if (capture) begin
        pend_valid  <= 1'b1;
        pend_target <= live_target;
      end else if (take_branch) begin
        pend_valid  <= 1'b0;
      end
      if (branch_valid_i && (branch_target_i[1:0] != 2'b00)) misalign_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed plan steps plus random traffic against
// a rule-level reference model, and a wrap-around instance.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_valid_i, fetch_ready_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o, pc_plus4_o;
  logic        pc_valid_o, redirect_o, misalign_err_o;

  logic [31:0] w_pc, w_plus4;
  logic        w_valid, w_redir, w_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_started, m_bubble, m_pend_v, m_redir, m_err;
  logic [31:0] m_pend_t;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .branch_valid_i(branch_valid_i),
    .branch_target_i(branch_target_i), .fetch_ready_i(fetch_ready_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_plus4_o(pc_plus4_o),
    .redirect_o(redirect_o), .misalign_err_o(misalign_err_o)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_i(1'b0), .branch_valid_i(1'b0),
    .branch_target_i(32'h0), .fetch_ready_i(1'b1),
    .pc_o(w_pc), .pc_valid_o(w_valid), .pc_plus4_o(w_plus4),
    .redirect_o(w_redir), .misalign_err_o(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_started = 0; m_bubble = 0; m_pend_v = 0;
    m_pend_t = 32'h0; m_redir = 0; m_err = 0;
  endtask

  // One clock of the rules: presentation is valid once started and not in the
  // post-redirect bubble; a redirect needs a presented PC and no stall.
  task automatic model_step();
    logic        valid, can_redir, branch;
    logic [31:0] tgt, aligned;
    valid     = m_started && !m_bubble;
    can_redir = valid && !stall_i;
    aligned   = branch_target_i & 32'hFFFF_FFFC;
    branch    = 0;
    tgt       = 32'h0;
    if (can_redir && branch_valid_i) begin branch = 1; tgt = aligned; end
    else if (can_redir && m_pend_v)  begin branch = 1; tgt = m_pend_t; end
    if (branch_valid_i) m_err = m_err | (branch_target_i[1:0] != 2'b00);
    if (branch_valid_i && !can_redir) begin m_pend_v = 1; m_pend_t = aligned; end
    else if (branch) m_pend_v = 0;
    if (branch) m_pc = tgt;
    else if (valid && fetch_ready_i && !stall_i) m_pc = m_pc + 32'd4;
    m_redir   = branch;
    m_bubble  = branch;
    m_started = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc_o, m_pc);
    chk({tag, ".valid"},  32'(pc_valid_o), 32'(m_started && !m_bubble));
    chk({tag, ".plus4"},  pc_plus4_o, m_pc + 32'd4);
    chk({tag, ".redir"},  32'(redirect_o), 32'(m_redir));
    chk({tag, ".err"},    32'(misalign_err_o), 32'(m_err));
  endtask

  task automatic cyc(input logic st, input logic bv, input logic [31:0] bt, input logic rdy);
    stall_i = st; branch_valid_i = bv; branch_target_i = bt; fetch_ready_i = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
  endtask

  initial begin
    rst_n = 0; stall_i = 0; branch_valid_i = 0; branch_target_i = 0; fetch_ready_i = 1;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pc_const", pc_o, 32'h0);
    chk("wrap.reset_pc", w_pc, 32'hFFFF_FFF8);
    rst_n = 1;

    // Plan: one invalid cycle, then 0,4,8
    chk("idle.valid", 32'(pc_valid_o), 32'd0);
    cyc(0, 0, 0, 1); chk("seq0", pc_o, 32'h0);
    chk("wrap.seq0", w_pc, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1); chk("seq4", pc_o, 32'h4);
    chk("wrap.seq1", w_pc, 32'hFFFF_FFFC);
    chk("wrap.plus4", w_plus4, 32'h0);
    cyc(0, 0, 0, 1); chk("seq8", pc_o, 32'h8);
    chk("wrap.seq2", w_pc, 32'h0);

    // Branch at 0x8 to 0x100
    cyc(0, 1, 32'h100, 1);
    chk("br.pc", pc_o, 32'h100);
    chk("br.redir", 32'(redirect_o), 32'd1);
    chk("br.bubble", 32'(pc_valid_o), 32'd0);
    cyc(0, 0, 0, 1); chk("br.pc_valid", 32'(pc_valid_o), 32'd1);
    chk("br.hold", pc_o, 32'h100);
    cyc(0, 0, 0, 1); chk("br.next", pc_o, 32'h104);

    // Go to 0x20, stall 3 cycles with two branches during the stall
    cyc(0, 1, 32'h20, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 32'h200, 1); chk("stall.hold1", pc_o, 32'h20);
    cyc(1, 1, 32'h300, 1); chk("stall.hold2", pc_o, 32'h20);
    cyc(1, 0, 0, 1);       chk("stall.hold3", pc_o, 32'h20);
    chk("stall.noredir", 32'(redirect_o), 32'd0);
    cyc(0, 0, 0, 1);
    chk("stall.newest", pc_o, 32'h300);
    chk("stall.redir", 32'(redirect_o), 32'd1);
    cyc(0, 0, 0, 1); chk("stall.single", 32'(redirect_o), 32'd0);

    // fetch_ready low at 0x40
    cyc(0, 1, 32'h40, 1);
    cyc(0, 0, 0, 0); chk("rdy.hold1", pc_o, 32'h40);
    cyc(0, 0, 0, 0); chk("rdy.hold2", pc_o, 32'h40);
    chk("rdy.valid", 32'(pc_valid_o), 32'd1);
    cyc(0, 0, 0, 1); chk("rdy.adv", pc_o, 32'h44);

    // Misaligned target
    cyc(0, 1, 32'h103, 1);
    chk("mis.pc", pc_o, 32'h100);
    chk("mis.err", 32'(misalign_err_o), 32'd1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("mis.sticky", 32'(misalign_err_o), 32'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          $urandom, ($urandom_range(0, 3) != 0));
    end

    // Mid-run reset with a branch left pending
    cyc(1, 1, 32'h500, 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    check_all("midreset");
    chk("midreset.err", 32'(misalign_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    chk("midreset.nopend", pc_o, 32'h4);

    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
